// File: rtl/ibex_cvxif_offload.sv
// CV-X-IF initiator: issues one offloaded instruction to an external coprocessor,
// waits for its tagged result and writes it back to the integer register file.
module ibex_cvxif_offload #(
    parameter int unsigned IdWidth       = 4,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic               clk_i,
    input  logic               rst_ni,

    input  logic               offload_valid_i,
    output logic               offload_ready_o,
    input  logic [31:0]        offload_instr_i,
    input  logic [31:0]        offload_rs1_i,
    input  logic [31:0]        offload_rs2_i,
    output logic               stall_o,
    output logic               illegal_insn_o,
    output logic               timeout_o,

    output logic               rf_we_o,
    output logic [4:0]         rf_waddr_o,
    output logic [31:0]        rf_wdata_o,

    output logic               x_issue_valid_o,
    input  logic               x_issue_ready_i,
    output logic [31:0]        x_issue_instr_o,
    output logic [63:0]        x_issue_rs_o,
    output logic [IdWidth-1:0] x_issue_id_o,
    input  logic               x_issue_accept_i,
    input  logic               x_issue_writeback_i,

    input  logic               x_result_valid_i,
    output logic               x_result_ready_o,
    input  logic [IdWidth-1:0] x_result_id_i,
    input  logic [4:0]         x_result_rd_i,
    input  logic               x_result_we_i,
    input  logic [31:0]        x_result_data_i
);

    localparam int unsigned TmoW    = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    localparam int unsigned TmoLast = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [IdWidth-1:0]   id_cnt_q;
    logic [IdWidth-1:0]   id_q;
    logic [31:0]          instr_q, rs1_q, rs2_q;
    logic [TmoW-1:0]      tmo_cnt_q;
    logic                 illegal_q, illegal_d;
    logic                 timeout_q, timeout_d;
    logic                 rf_we_q;
    logic [4:0]           rf_waddr_q;
    logic [31:0]          rf_wdata_q;

    logic                 issue_hs;
    logic                 issue_wb;
    logic                 result_hit;
    logic                 tmo_hit;
    logic                 res_write;

    assign issue_hs   = (state_q == S_ISSUE) && x_issue_ready_i;
    assign issue_wb   = issue_hs && x_issue_accept_i && x_issue_writeback_i;
    assign x_result_ready_o = issue_wb || (state_q == S_WAIT);
    assign result_hit = x_result_ready_o && x_result_valid_i && (x_result_id_i == id_q);
    assign tmo_hit    = (TimeoutCycles != 0)
                     && ((state_q == S_ISSUE) || (state_q == S_WAIT))
                     && (tmo_cnt_q == TmoW'(TmoLast));
    assign res_write  = x_result_we_i && (x_result_rd_i != 5'd0);

    // Next state; a transaction that completes in the timeout cycle wins over the abort.
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (offload_valid_i) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (issue_hs) begin
                    if (!x_issue_accept_i) begin
                        state_d   = S_IDLE;
                        illegal_d = 1'b1;
                    end else if (!x_issue_writeback_i) begin
                        state_d = S_IDLE;
                    end else if (result_hit) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (result_hit) state_d = S_WB;
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (tmo_hit && ((state_d == S_ISSUE) || (state_d == S_WAIT))) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            id_cnt_q   <= '0;
            id_q       <= '0;
            instr_q    <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            tmo_cnt_q  <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;

            if ((state_q == S_IDLE) && offload_valid_i) begin
                instr_q  <= offload_instr_i;
                rs1_q    <= offload_rs1_i;
                rs2_q    <= offload_rs2_i;
                id_q     <= id_cnt_q;
                id_cnt_q <= id_cnt_q + IdWidth'(1);
            end

            // Entry into ISSUE is only from IDLE, so clearing in IDLE restarts the count.
            if (state_q == S_IDLE) begin
                tmo_cnt_q <= '0;
            end else if ((state_q == S_ISSUE) || (state_q == S_WAIT)) begin
                tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
            end

            if (state_d == S_WB) begin
                rf_we_q    <= res_write;
                rf_waddr_q <= res_write ? x_result_rd_i : 5'd0;
                rf_wdata_q <= res_write ? x_result_data_i : 32'd0;
            end else begin
                rf_we_q    <= 1'b0;
                rf_waddr_q <= '0;
                rf_wdata_q <= '0;
            end
        end
    end

    assign offload_ready_o = (state_q == S_IDLE);
    assign stall_o         = (state_q != S_IDLE) || offload_valid_i;
    assign illegal_insn_o  = illegal_q;
    assign timeout_o       = timeout_q;
    assign rf_we_o         = rf_we_q;
    assign rf_waddr_o      = rf_waddr_q;
    assign rf_wdata_o      = rf_wdata_q;
    assign x_issue_valid_o = (state_q == S_ISSUE);
    assign x_issue_instr_o = instr_q;
    assign x_issue_rs_o    = {rs2_q, rs1_q};
    assign x_issue_id_o    = id_q;

endmodule

// File: tb/tb_ibex_cvxif_offload.sv
// Directed bench for ibex_cvxif_offload: table of single-cycle-responder transactions
// plus hand-written multi-cycle sequences (delays, id mismatch, timeout, reset, id wrap).
module tb_ibex_cvxif_offload;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        offload_valid_i;
    logic        offload_ready_o;
    logic [31:0] offload_instr_i, offload_rs1_i, offload_rs2_i;
    logic        stall_o, illegal_insn_o, timeout_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        x_issue_valid_o, x_issue_ready_i;
    logic [31:0] x_issue_instr_o;
    logic [63:0] x_issue_rs_o;
    logic [3:0]  x_issue_id_o;
    logic        x_issue_accept_i, x_issue_writeback_i;
    logic        x_result_valid_i, x_result_ready_o;
    logic [3:0]  x_result_id_i;
    logic [4:0]  x_result_rd_i;
    logic        x_result_we_i;
    logic [31:0] x_result_data_i;

    ibex_cvxif_offload #(.IdWidth(4), .TimeoutCycles(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .offload_valid_i(offload_valid_i), .offload_ready_o(offload_ready_o),
        .offload_instr_i(offload_instr_i), .offload_rs1_i(offload_rs1_i),
        .offload_rs2_i(offload_rs2_i), .stall_o(stall_o),
        .illegal_insn_o(illegal_insn_o), .timeout_o(timeout_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .x_issue_valid_o(x_issue_valid_o), .x_issue_ready_i(x_issue_ready_i),
        .x_issue_instr_o(x_issue_instr_o), .x_issue_rs_o(x_issue_rs_o),
        .x_issue_id_o(x_issue_id_o), .x_issue_accept_i(x_issue_accept_i),
        .x_issue_writeback_i(x_issue_writeback_i),
        .x_result_valid_i(x_result_valid_i), .x_result_ready_o(x_result_ready_o),
        .x_result_id_i(x_result_id_i), .x_result_rd_i(x_result_rd_i),
        .x_result_we_i(x_result_we_i), .x_result_data_i(x_result_data_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        acc;
        logic        wb;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_ill;
        logic        e_stall;
    } vec_t;

    vec_t       vecs[6];
    logic [3:0] exp_id;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic clear_resp();
        x_issue_ready_i     = 1'b0;
        x_issue_accept_i    = 1'b0;
        x_issue_writeback_i = 1'b0;
        x_result_valid_i    = 1'b0;
        x_result_id_i       = '0;
        x_result_rd_i       = '0;
        x_result_we_i       = 1'b0;
        x_result_data_i     = '0;
    endtask

    task automatic start_offload(input logic [31:0] instr, input logic [31:0] rs1,
                                 input logic [31:0] rs2);
        offload_valid_i = 1'b1;
        offload_instr_i = instr;
        offload_rs1_i   = rs1;
        offload_rs2_i   = rs2;
        tick();
        offload_valid_i = 1'b0;
        offload_instr_i = '0;
        offload_rs1_i   = '0;
        offload_rs2_i   = '0;
    endtask

    initial begin
        //         instr         rs1           rs2           acc   wb    we    rd     data          e_we  e_addr e_data        e_ill e_stall
        vecs[0] = '{32'h0000_0053, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b1, 1'b1, 5'd5,  32'h4040_0000, 1'b1, 5'd5,  32'h4040_0000, 1'b0, 1'b1};
        vecs[1] = '{32'h1234_5678, 32'hAAAA_5555, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 1'b0};
        vecs[2] = '{32'h0800_0053, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
        vecs[3] = '{32'h1000_0053, 32'hCAFE_0000, 32'h0000_BEEF, 1'b1, 1'b1, 1'b1, 5'd0,  32'hDEAD_BEEF, 1'b0, 5'd0,  32'h0,         1'b0, 1'b1};
        vecs[4] = '{32'h1800_0053, 32'h0000_0003, 32'h0000_0004, 1'b1, 1'b1, 1'b0, 5'd7,  32'h0000_1234, 1'b0, 5'd0,  32'h0,         1'b0, 1'b1};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b1};

        rst_ni          = 1'b0;
        offload_valid_i = 1'b0;
        offload_instr_i = '0;
        offload_rs1_i   = '0;
        offload_rs2_i   = '0;
        clear_resp();
        exp_id = '0;

        repeat (2) @(posedge clk_i);
        mid();
        chk("rst_ready",   64'(offload_ready_o), 64'd1);
        chk("rst_stall",   64'(stall_o), 64'd0);
        chk("rst_ill",     64'(illegal_insn_o), 64'd0);
        chk("rst_tmo",     64'(timeout_o), 64'd0);
        chk("rst_rf",      {27'd0, rf_we_o, rf_waddr_o, rf_wdata_o}, 64'd0);
        chk("rst_ivalid",  64'(x_issue_valid_o), 64'd0);
        chk("rst_iinstr",  64'(x_issue_instr_o), 64'd0);
        chk("rst_irs",     x_issue_rs_o, 64'd0);
        chk("rst_iid",     64'(x_issue_id_o), 64'd0);
        chk("rst_rready",  64'(x_result_ready_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Table: combinational responder, result (if any) in the issue cycle.
        for (int i = 0; i < 6; i++) begin
            offload_valid_i = 1'b1;
            mid();
            chk("tbl_ready_idle", 64'(offload_ready_o), 64'd1);
            chk("tbl_stall_req",  64'(stall_o), 64'd1);
            offload_valid_i = 1'b0;
            start_offload(vecs[i].instr, vecs[i].rs1, vecs[i].rs2);
            x_issue_ready_i     = 1'b1;
            x_issue_accept_i    = vecs[i].acc;
            x_issue_writeback_i = vecs[i].wb;
            x_result_valid_i    = vecs[i].acc & vecs[i].wb;
            x_result_id_i       = exp_id;
            x_result_rd_i       = vecs[i].rd;
            x_result_we_i       = vecs[i].we;
            x_result_data_i     = vecs[i].data;
            mid();
            chk("tbl_ivalid", 64'(x_issue_valid_o), 64'd1);
            chk("tbl_iinstr", 64'(x_issue_instr_o), 64'(vecs[i].instr));
            chk("tbl_irs",    x_issue_rs_o, {vecs[i].rs2, vecs[i].rs1});
            chk("tbl_iid",    64'(x_issue_id_o), 64'(exp_id));
            chk("tbl_rready", 64'(x_result_ready_o), 64'(vecs[i].acc & vecs[i].wb));
            chk("tbl_stall",  64'(stall_o), 64'd1);
            tick();
            clear_resp();
            mid();
            chk("tbl_rf_we",    64'(rf_we_o), 64'(vecs[i].e_we));
            chk("tbl_rf_waddr", 64'(rf_waddr_o), 64'(vecs[i].e_addr));
            chk("tbl_rf_wdata", 64'(rf_wdata_o), 64'(vecs[i].e_data));
            chk("tbl_ill",      64'(illegal_insn_o), 64'(vecs[i].e_ill));
            chk("tbl_stall1",   64'(stall_o), 64'(vecs[i].e_stall));
            chk("tbl_tmo",      64'(timeout_o), 64'd0);
            tick();
            mid();
            chk("tbl_stall2", 64'(stall_o), 64'd0);
            chk("tbl_rf_we2", 64'(rf_we_o), 64'd0);
            chk("tbl_ill2",   64'(illegal_insn_o), 64'd0);
            tick();
            exp_id = exp_id + 4'd1;
        end

        // Result arrives three cycles after the issue handshake.
        start_offload(32'h0000_1053, 32'h3F80_0000, 32'h4000_0000);
        x_issue_ready_i = 1'b1; x_issue_accept_i = 1'b1; x_issue_writeback_i = 1'b1;
        mid();
        chk("dly_rready0", 64'(x_result_ready_o), 64'd1);
        tick();
        clear_resp();
        mid();
        chk("dly_ivalid_wait", 64'(x_issue_valid_o), 64'd0);
        chk("dly_rf_we1", 64'(rf_we_o), 64'd0);
        tick();
        mid();
        chk("dly_rf_we2", 64'(rf_we_o), 64'd0);
        tick();
        x_result_valid_i = 1'b1; x_result_id_i = exp_id; x_result_rd_i = 5'd12;
        x_result_we_i = 1'b1; x_result_data_i = 32'h3F80_0000;
        mid();
        chk("dly_rready3", 64'(x_result_ready_o), 64'd1);
        chk("dly_rf_we3",  64'(rf_we_o), 64'd0);
        tick();
        clear_resp();
        mid();
        chk("dly_rf_we4",    64'(rf_we_o), 64'd1);
        chk("dly_rf_waddr4", 64'(rf_waddr_o), 64'd12);
        chk("dly_rf_wdata4", 64'(rf_wdata_o), 64'h3F80_0000);
        tick();
        mid();
        chk("dly_rf_we5",    64'(rf_we_o), 64'd0);
        chk("dly_rf_waddr5", 64'(rf_waddr_o), 64'd0);
        chk("dly_ready5",    64'(offload_ready_o), 64'd1);
        tick();
        exp_id = exp_id + 4'd1;

        // Issue held off for four cycles; captured fields must not follow the ID inputs.
        start_offload(32'hABCD_0001, 32'h1111_2222, 32'h3333_4444);
        offload_instr_i = 32'h5555_5555;
        offload_rs1_i   = 32'h6666_6666;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("hold_ivalid", 64'(x_issue_valid_o), 64'd1);
            chk("hold_instr",  64'(x_issue_instr_o), 64'hABCD_0001);
            chk("hold_rs",     x_issue_rs_o, 64'h3333_4444_1111_2222);
            chk("hold_id",     64'(x_issue_id_o), 64'(exp_id));
            tick();
        end
        offload_instr_i = '0;
        offload_rs1_i   = '0;
        x_issue_ready_i = 1'b1; x_issue_accept_i = 1'b1; x_issue_writeback_i = 1'b0;
        mid();
        chk("hold_rready_nowb", 64'(x_result_ready_o), 64'd0);
        tick();
        clear_resp();
        mid();
        chk("hold_idle", 64'(offload_ready_o), 64'd1);
        chk("hold_rf_we", 64'(rf_we_o), 64'd0);
        tick();
        exp_id = exp_id + 4'd1;

        // Wrong-id result is acknowledged and dropped, the matching one is written.
        start_offload(32'h0000_2053, 32'h7, 32'h8);
        x_issue_ready_i = 1'b1; x_issue_accept_i = 1'b1; x_issue_writeback_i = 1'b1;
        x_result_valid_i = 1'b1; x_result_id_i = exp_id + 4'd1; x_result_rd_i = 5'd3;
        x_result_we_i = 1'b1; x_result_data_i = 32'h0000_0BAD;
        mid();
        chk("wid_rready0", 64'(x_result_ready_o), 64'd1);
        tick();
        x_issue_ready_i = 1'b0; x_issue_accept_i = 1'b0; x_issue_writeback_i = 1'b0;
        x_result_id_i = exp_id; x_result_rd_i = 5'd9; x_result_data_i = 32'h0000_600D;
        mid();
        chk("wid_rready1", 64'(x_result_ready_o), 64'd1);
        chk("wid_rf_we1",  64'(rf_we_o), 64'd0);
        tick();
        clear_resp();
        mid();
        chk("wid_rf_we2",    64'(rf_we_o), 64'd1);
        chk("wid_rf_waddr2", 64'(rf_waddr_o), 64'd9);
        chk("wid_rf_wdata2", 64'(rf_wdata_o), 64'h600D);
        tick();
        mid();
        chk("wid_rf_we3", 64'(rf_we_o), 64'd0);
        tick();
        exp_id = exp_id + 4'd1;

        // Stray result while idle is not acknowledged.
        x_result_valid_i = 1'b1; x_result_id_i = exp_id; x_result_rd_i = 5'd4;
        x_result_we_i = 1'b1; x_result_data_i = 32'h1;
        mid();
        chk("stray_rready", 64'(x_result_ready_o), 64'd0);
        chk("stray_stall",  64'(stall_o), 64'd0);
        tick();
        clear_resp();
        mid();
        chk("stray_rf_we", 64'(rf_we_o), 64'd0);
        tick();

        // Coprocessor never takes the issue: abort after eight cycles.
        start_offload(32'h0000_3053, 32'h1, 32'h1);
        for (int k = 0; k < 8; k++) begin
            mid();
            chk("tmo_ivalid", 64'(x_issue_valid_o), 64'd1);
            chk("tmo_early",  64'(timeout_o), 64'd0);
            tick();
        end
        mid();
        chk("tmo_pulse",  64'(timeout_o), 64'd1);
        chk("tmo_ivalid_drop", 64'(x_issue_valid_o), 64'd0);
        chk("tmo_ready",  64'(offload_ready_o), 64'd1);
        chk("tmo_rf_we",  64'(rf_we_o), 64'd0);
        tick();
        mid();
        chk("tmo_pulse_end", 64'(timeout_o), 64'd0);
        tick();
        exp_id = exp_id + 4'd1;

        // Reset while waiting for a result.
        start_offload(32'h0000_4053, 32'h2, 32'h3);
        x_issue_ready_i = 1'b1; x_issue_accept_i = 1'b1; x_issue_writeback_i = 1'b1;
        tick();
        clear_resp();
        mid();
        chk("rstw_rready", 64'(x_result_ready_o), 64'd1);
        #1 rst_ni = 1'b0;
        #1;
        chk("rstw_ready",  64'(offload_ready_o), 64'd1);
        chk("rstw_rready0", 64'(x_result_ready_o), 64'd0);
        chk("rstw_stall",  64'(stall_o), 64'd0);
        chk("rstw_rf_we",  64'(rf_we_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        mid();
        chk("rstw_ill", 64'(illegal_insn_o), 64'd0);
        chk("rstw_tmo", 64'(timeout_o), 64'd0);
        chk("rstw_rf_we2", 64'(rf_we_o), 64'd0);
        tick();

        // Id counter restarts at 0 and wraps over 17 offloads.
        for (int i = 0; i < 17; i++) begin
            start_offload(32'(i), 32'h0, 32'h0);
            x_issue_ready_i = 1'b1; x_issue_accept_i = 1'b1; x_issue_writeback_i = 1'b0;
            mid();
            chk("wrap_id", 64'(x_issue_id_o), 64'(i % 16));
            tick();
            clear_resp();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
